sdram_sched: RTL and testbench

- Command scheduler that feeds the sdram_io command FIFO with data_t words: {cmd, ba, column[8:0], data[15:0]}.
- Sequences SDRAM power-up: PALL, REF x INIT_REFS, MRS.
- Inserts a periodic refresh (PALL + REF) on each icnt_ovf pulse.
- Arbitrates one write port and two read ports round-robin, tracks one open row per bank, and emits PRE/ACT/READ/WRITE.
- All tRC/tRCD/tRP timing is enforced downstream by sdram_io stalls; this block only orders commands.

---
 rtl/sdram_sched.sv | 210 +++++++++++++++++++++
 tb/tb_sdram_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_sched.sv
// SDRAM command scheduler: power-up sequence, periodic refresh, and round-robin
// arbitration of one write and two read ports into the sdram_io command FIFO.
module sdram_sched #(
    parameter int BURST     = 8,
    parameter int INIT_REFS = 2,
    parameter bit PAGE_OPEN = 1'b1
) (
    input  logic        clkSDRAM,
    input  logic        n_reset,
    input  logic        icnt_ovf,
    input  logic        fifo_full,
    output logic        fifo_wrreq,
    output logic [29:0] fifo_in,      // data_t: {cmd[2:0], ba[1:0], column[8:0], data[15:0]}
    input  logic        wr_req,
    input  logic [23:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
    input  logic [1:0]  rd_req,
    input  logic [23:0] rd_addr0,
    input  logic [23:0] rd_addr1,
    output logic [1:0]  rd_ack,
    output logic        init_done
);

    typedef enum logic [2:0] {
        C_NOP, C_PALL, C_REF, C_MRS, C_ACT, C_PRE, C_READ, C_WRITE
    } cmd_e;

    typedef struct packed {
        cmd_e        cmd;
        logic [1:0]  ba;
        logic [8:0]  column;
        logic [15:0] data;
    } data_t;

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_INIT_PALL, S_INIT_REF, S_INIT_MRS, S_IDLE,
        S_REF_PALL, S_REF_REF, S_PRE, S_ACT, S_CMD, S_CLOSE
    } state_e;

    typedef enum logic [1:0] { P_WR, P_RD0, P_RD1 } port_e;

    localparam logic [8:0] COL_MASK = ~(9'(BURST) - 9'd1);

    state_e      state;
    port_e       rr_ptr;
    port_e       gnt;
    logic        gnt_any;
    logic [23:0] gnt_addr;
    logic        refresh_pending;
    logic [2:0]  ref_cnt;
    logic [3:0]  bank_open;
    logic [12:0] bank_row [4];
    logic [1:0]  l_ba;
    logic [12:0] l_row;
    logic [8:0]  l_col;
    logic [15:0] l_data;
    logic        l_wr;
    logic        l_port;
    data_t       word;
    logic        emit;
    logic        wr_fire;

    // First asserted requester strictly after the pointer, wrapping wr -> rd0 -> rd1.
    always_comb begin
        gnt_any = 1'b1;
        gnt     = P_WR;
        case (rr_ptr)
            P_WR: begin
                if (rd_req[0])      gnt = P_RD0;
                else if (rd_req[1]) gnt = P_RD1;
                else if (wr_req)    gnt = P_WR;
                else                gnt_any = 1'b0;
            end
            P_RD0: begin
                if (rd_req[1])      gnt = P_RD1;
                else if (wr_req)    gnt = P_WR;
                else if (rd_req[0]) gnt = P_RD0;
                else                gnt_any = 1'b0;
            end
            default: begin
                if (wr_req)         gnt = P_WR;
                else if (rd_req[0]) gnt = P_RD0;
                else if (rd_req[1]) gnt = P_RD1;
                else                gnt_any = 1'b0;
            end
        endcase
        case (gnt)
            P_WR:    gnt_addr = wr_addr;
            P_RD0:   gnt_addr = rd_addr0;
            default: gnt_addr = rd_addr1;
        endcase
    end

    always_comb begin
        word = '0;
        emit = 1'b1;
        case (state)
            S_INIT_PALL, S_REF_PALL: word.cmd = C_PALL;
            S_INIT_REF, S_REF_REF:   word.cmd = C_REF;
            S_INIT_MRS:              word.cmd = C_MRS;
            S_PRE, S_CLOSE: begin
                word.cmd = C_PRE;
                word.ba  = l_ba;
            end
            S_ACT: begin
                word.cmd  = C_ACT;
                word.ba   = l_ba;
                word.data = {3'b000, l_row};
            end
            S_CMD: begin
                word.ba = l_ba;
                if (l_wr) begin
                    word.cmd    = C_WRITE;
                    word.column = l_col;
                    word.data   = l_data;
                end else begin
                    word.cmd    = C_READ;
                    word.column = l_col & COL_MASK;
                    word.data   = {15'd0, l_port};
                end
            end
            default: emit = 1'b0;
        endcase
    end

    assign wr_fire    = emit & ~fifo_full;
    assign fifo_wrreq = wr_fire;
    assign fifo_in    = wr_fire ? word : '0;
    assign wr_ack     = wr_fire && (state == S_CMD) && l_wr;
    assign rd_ack[0]  = wr_fire && (state == S_CMD) && !l_wr && !l_port;
    assign rd_ack[1]  = wr_fire && (state == S_CMD) && !l_wr && l_port;

    always_ff @(posedge clkSDRAM or negedge n_reset) begin
        if (!n_reset) begin
            state           <= S_INIT_WAIT;
            rr_ptr          <= P_WR;
            refresh_pending <= 1'b0;
            init_done       <= 1'b0;
            ref_cnt         <= '0;
            bank_open       <= '0;
            for (int unsigned b = 0; b < 4; b++) bank_row[b] <= '0;
            l_ba            <= '0;
            l_row           <= '0;
            l_col           <= '0;
            l_data          <= '0;
            l_wr            <= 1'b0;
            l_port          <= 1'b0;
        end else begin
            if (icnt_ovf && init_done) refresh_pending <= 1'b1;
            case (state)
                S_INIT_WAIT: if (icnt_ovf) state <= S_INIT_PALL;
                S_INIT_PALL: if (wr_fire) begin
                    ref_cnt <= '0;
                    state   <= S_INIT_REF;
                end
                S_INIT_REF: if (wr_fire) begin
                    if (ref_cnt == 3'(INIT_REFS - 1)) state <= S_INIT_MRS;
                    else ref_cnt <= ref_cnt + 3'd1;
                end
                S_INIT_MRS: if (wr_fire) begin
                    init_done <= 1'b1;
                    state     <= S_IDLE;
                end
                S_IDLE: begin
                    // Clearing here overrides a same-cycle tick set above.
                    if (refresh_pending || icnt_ovf) begin
                        refresh_pending <= 1'b0;
                        state           <= S_REF_PALL;
                    end else if (gnt_any) begin
                        l_ba   <= gnt_addr[23:22];
                        l_row  <= gnt_addr[21:9];
                        l_col  <= gnt_addr[8:0];
                        l_data <= wr_data;
                        l_wr   <= (gnt == P_WR);
                        l_port <= (gnt == P_RD1);
                        rr_ptr <= gnt;
                        if (!bank_open[gnt_addr[23:22]])
                            state <= S_ACT;
                        else if (bank_row[gnt_addr[23:22]] == gnt_addr[21:9])
                            state <= S_CMD;
                        else
                            state <= S_PRE;
                    end
                end
                S_REF_PALL: if (wr_fire) begin
                    bank_open <= '0;
                    state     <= S_REF_REF;
                end
                S_REF_REF: if (wr_fire) state <= S_IDLE;
                S_PRE: if (wr_fire) begin
                    bank_open[l_ba] <= 1'b0;
                    state           <= S_ACT;
                end
                S_ACT: if (wr_fire) begin
                    bank_row[l_ba]  <= l_row;
                    bank_open[l_ba] <= 1'b1;
                    state           <= S_CMD;
                end
                S_CMD: if (wr_fire) state <= PAGE_OPEN ? S_IDLE : S_CLOSE;
                S_CLOSE: if (wr_fire) begin
                    bank_open[l_ba] <= 1'b0;
                    state           <= S_IDLE;
                end
                default: state <= S_INIT_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_sched.sv
// Scoreboard bench for sdram_sched: expected FIFO words and acks are queued by
// the stimulus and popped by a negedge monitor whenever fifo_wrreq is high.
module tb_sdram_sched;

    localparam logic [2:0] C_PALL = 3'd1, C_REF = 3'd2, C_MRS = 3'd3, C_ACT = 3'd4,
                           C_PRE = 3'd5, C_READ = 3'd6, C_WRITE = 3'd7;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        icnt_ovf;
    logic        fifo_full;
    logic        fifo_wrreq;
    logic [29:0] fifo_in;
    logic        wr_req;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic [1:0]  rd_req;
    logic [23:0] rd_addr0;
    logic [23:0] rd_addr1;
    logic [1:0]  rd_ack;
    logic        init_done;

    always #5 clk = ~clk;

    sdram_sched #(.BURST(8), .INIT_REFS(2), .PAGE_OPEN(1'b1)) dut (
        .clkSDRAM  (clk),
        .n_reset   (n_reset),
        .icnt_ovf  (icnt_ovf),
        .fifo_full (fifo_full),
        .fifo_wrreq(fifo_wrreq),
        .fifo_in   (fifo_in),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .rd_req    (rd_req),
        .rd_addr0  (rd_addr0),
        .rd_addr1  (rd_addr1),
        .rd_ack    (rd_ack),
        .init_done (init_done)
    );

    typedef struct {
        logic [29:0] word;
        logic [2:0]  ack;   // {rd_ack[1], rd_ack[0], wr_ack}
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic init_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] c, input logic [1:0] ba, input logic [8:0] col,
                        input logic [15:0] d, input logic [2:0] ack);
        exp_t e;
        e.word = {c, ba, col, d};
        e.ack  = ack;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (n_reset === 1'b1) begin
            if (init_chk) begin
                check("init_done_after_mrs", {31'd0, init_done}, 32'd1);
                init_chk = 1'b0;
            end
            if (fifo_full) check("no_wrreq_when_full", {31'd0, fifo_wrreq}, 32'd0);
            if (fifo_wrreq) begin
                if (q.size() == 0) begin
                    check("unexpected_write", {2'b00, fifo_in}, 32'd0);
                end else begin
                    exp_t e;
                    logic [2:0] ec;
                    e = q.pop_front();
                    check("cmd_word", {2'b00, fifo_in}, {2'b00, e.word});
                    check("acks", {29'd0, rd_ack, wr_ack}, {29'd0, e.ack});
                    ec = e.word[29:27];
                    if (ec == C_MRS) begin
                        check("init_done_at_mrs", {31'd0, init_done}, 32'd0);
                        init_chk = 1'b1;
                    end
                end
            end else if ({rd_ack, wr_ack} != 3'b000) begin
                check("ack_without_write", {29'd0, rd_ack, wr_ack}, 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input logic [2:0] mask, input string name);
        int   n = 0;
        logic seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            if (({rd_ack, wr_ack} & mask) != 3'b000) seen = 1'b1;
            n++;
        end
        if (!seen) check(name, {29'd0, rd_ack, wr_ack}, {29'd0, mask});
        @(posedge clk);
        #1;
        if (mask[0]) wr_req = 1'b0;
        rd_req = rd_req & ~mask[2:1];
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check(name, q.size(), 32'd0);
            q.delete();
        end
        tick(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fifo_wrreq"}, {31'd0, fifo_wrreq}, 32'd0);
        check({tag, "_fifo_in"}, {2'b00, fifo_in}, 32'd0);
        check({tag, "_wr_ack"}, {31'd0, wr_ack}, 32'd0);
        check({tag, "_rd_ack"}, {30'd0, rd_ack}, 32'd0);
        check({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
    endtask

    initial begin
        int acks;
        int n;
        n_reset = 1'b0; icnt_ovf = 1'b0; fifo_full = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = 2'b00; rd_addr0 = '0; rd_addr1 = '0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        n_reset = 1'b1;
        tick(3);
        check("wait_no_cmd", {31'd0, fifo_wrreq}, 32'd0);

        // Init with a write already pending (must not be acked before init_done),
        // plus a second tick during INIT_REF that must be dropped.
        push(C_PALL, 2'd0, 9'd0, 16'd0, 3'b000);
        push(C_REF,  2'd0, 9'd0, 16'd0, 3'b000);
        push(C_REF,  2'd0, 9'd0, 16'd0, 3'b000);
        push(C_MRS,  2'd0, 9'd0, 16'd0, 3'b000);
        push(C_ACT,  2'd1, 9'd0, 16'h0055, 3'b000);
        push(C_WRITE, 2'd1, 9'h004, 16'hBEEF, 3'b001);
        wr_addr = {2'd1, 13'h0055, 9'h004};
        wr_data = 16'hBEEF;
        wr_req  = 1'b1;
        tick(2);
        icnt_ovf = 1'b1; tick(1); icnt_ovf = 1'b0; tick(1);
        icnt_ovf = 1'b1; tick(1); icnt_ovf = 1'b0;
        wait_ack(3'b001, "wr1_ack_timeout");
        drain("init_wr_drain");

        // Row hit read on port 0: column low bits cleared.
        push(C_READ, 2'd1, 9'h008, 16'h0000, 3'b010);
        rd_addr0 = {2'd1, 13'h0055, 9'h00D};
        rd_req[0] = 1'b1;
        wait_ack(3'b010, "rd0_ack_timeout");
        drain("rd0_drain");

        // Row miss on port 1: PRE, ACT, READ with id 1.
        push(C_PRE,  2'd1, 9'd0, 16'd0, 3'b000);
        push(C_ACT,  2'd1, 9'd0, 16'h0056, 3'b000);
        push(C_READ, 2'd1, 9'h010, 16'h0001, 3'b100);
        rd_addr1 = {2'd1, 13'h0056, 9'h013};
        rd_req[1] = 1'b1;
        wait_ack(3'b100, "rd1_ack_timeout");
        drain("rd1_drain");

        // All three held: pointer at rd1, so order is wr, rd0, rd1, wr.
        push(C_WRITE, 2'd1, 9'h020, 16'h1234, 3'b001);
        push(C_READ,  2'd1, 9'h030, 16'h0000, 3'b010);
        push(C_READ,  2'd1, 9'h040, 16'h0001, 3'b100);
        push(C_WRITE, 2'd1, 9'h020, 16'h1234, 3'b001);
        wr_addr  = {2'd1, 13'h0056, 9'h020};
        wr_data  = 16'h1234;
        rd_addr0 = {2'd1, 13'h0056, 9'h031};
        rd_addr1 = {2'd1, 13'h0056, 9'h047};
        wr_req = 1'b1; rd_req = 2'b11;
        acks = 0; n = 0;
        while (acks < 4 && n < 200) begin
            @(negedge clk);
            if ({rd_ack, wr_ack} != 3'b000) acks++;
            n++;
        end
        if (acks < 4) check("rr_ack_count", acks, 32'd4);
        @(posedge clk); #1;
        wr_req = 1'b0; rd_req = 2'b00;
        drain("rr_drain");

        // Tick and read request together in IDLE: refresh first, then ACT again.
        push(C_PALL, 2'd0, 9'd0, 16'd0, 3'b000);
        push(C_REF,  2'd0, 9'd0, 16'd0, 3'b000);
        push(C_ACT,  2'd1, 9'd0, 16'h0056, 3'b000);
        push(C_READ, 2'd1, 9'h0F8, 16'h0000, 3'b010);
        rd_addr0 = {2'd1, 13'h0056, 9'h0FF};
        rd_req[0] = 1'b1;
        icnt_ovf = 1'b1; tick(1); icnt_ovf = 1'b0;
        wait_ack(3'b010, "ref_rd0_ack_timeout");
        drain("ref_rd0_drain");

        // FIFO full stalls ACT; two ticks mid-transaction yield one refresh after.
        push(C_ACT,   2'd2, 9'd0, 16'h1ABC, 3'b000);
        push(C_WRITE, 2'd2, 9'h1FF, 16'hA5A5, 3'b001);
        push(C_PALL,  2'd0, 9'd0, 16'd0, 3'b000);
        push(C_REF,   2'd0, 9'd0, 16'd0, 3'b000);
        wr_addr = {2'd2, 13'h1ABC, 9'h1FF};
        wr_data = 16'hA5A5;
        fifo_full = 1'b1;
        wr_req = 1'b1;
        tick(2);
        icnt_ovf = 1'b1; tick(1); icnt_ovf = 1'b0; tick(1);
        icnt_ovf = 1'b1; tick(1); icnt_ovf = 1'b0; tick(1);
        fifo_full = 1'b0;
        wait_ack(3'b001, "full_wr_ack_timeout");
        drain("full_drain");

        // Reset while ACT is stalled: outputs drop at once, no ack afterwards.
        rd_addr1 = {2'd3, 13'h0001, 9'h000};
        fifo_full = 1'b1;
        rd_req[1] = 1'b1;
        tick(3);
        n_reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        fifo_full = 1'b0;
        tick(2);
        n_reset = 1'b1;
        tick(4);
        check("post_reset_init_done", {31'd0, init_done}, 32'd0);
        rd_req = 2'b00;

        // Init reruns on the next tick.
        push(C_PALL, 2'd0, 9'd0, 16'd0, 3'b000);
        push(C_REF,  2'd0, 9'd0, 16'd0, 3'b000);
        push(C_REF,  2'd0, 9'd0, 16'd0, 3'b000);
        push(C_MRS,  2'd0, 9'd0, 16'd0, 3'b000);
        icnt_ovf = 1'b1; tick(1); icnt_ovf = 1'b0;
        drain("reinit_drain");
        check("reinit_done", {31'd0, init_done}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
